// File: rtl/tx_byte_queue_if.sv
// Handshake bundle between a byte producer/serial transmitter and tx_byte_queue.
// The overflow signal exists only when TX_BYTE_QUEUE_OVERFLOW_EN is defined.
interface tx_byte_queue_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_busy;
`ifdef TX_BYTE_QUEUE_OVERFLOW_EN
    logic          overflow;

    modport master (
        output wr_en, wr_data, tx_busy,
        input  full, empty, count, tx_start, tx_data, overflow
    );
    modport slave (
        input  wr_en, wr_data, tx_busy,
        output full, empty, count, tx_start, tx_data, overflow
    );
`else
    modport master (
        output wr_en, wr_data, tx_busy,
        input  full, empty, count, tx_start, tx_data
    );
    modport slave (
        input  wr_en, wr_data, tx_busy,
        output full, empty, count, tx_start, tx_data
    );
`endif
endinterface

// File: rtl/tx_byte_queue.sv
// Circular byte queue draining one byte at a time into a serial transmitter.
// Optional sticky dropped-write flag enabled by defining TX_BYTE_QUEUE_OVERFLOW_EN.
module tx_byte_queue #(
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    tx_byte_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    logic [7:0]    mem [DEPTH];

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_start_q, tx_start_d;
    logic [1:0]    lost_q, lost_d;

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    // full is taken from the registered count, so a same-cycle pop never frees room for a push
    assign push  = bus.wr_en & ~full;
    assign pop   = (state_q == IDLE) & ~empty & ~bus.tx_busy;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        lost_d     = lost_q;
        count_d    = count_q + CW'(push) - CW'(pop);

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            tx_data_d = mem[rd_ptr_q];
        end

        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d    = LAUNCH;
                    tx_start_d = 1'b1;
                end
            end
            LAUNCH: begin
                state_d = WAIT_BUSY;
                lost_d  = 2'd0;
            end
            WAIT_BUSY: begin
                // give up after four quiet cycles so a missed handshake cannot stall the queue
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (lost_q == 2'd3) begin
                    state_d = IDLE;
                end else begin
                    lost_d = lost_q + 2'd1;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            lost_q     <= 2'd0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            lost_q     <= lost_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.wr_data;
        end
    end

`ifdef TX_BYTE_QUEUE_OVERFLOW_EN
    logic overflow_q, overflow_d;

    always_comb begin
        overflow_d = overflow_q | (bus.wr_en & full);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign bus.overflow = overflow_q;
`endif

    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.count    = count_q;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
endmodule

// File: tb/tb_tx_byte_queue.sv
// Self-checking bench for tx_byte_queue: scoreboard of pushed bytes against launched bytes,
// with a simple transmitter model that raises tx_busy for a programmable number of cycles.
module tb_tx_byte_queue;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tx_byte_queue_if #(.DEPTH(DEPTH)) bus ();

    tx_byte_queue #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q [$];
    int launches   = 0;
    int last_start = 0;
    int prev_start = 0;
    int cyc        = 0;

    int   busy_len  = 10;
    int   model_cnt = 0;
    logic hold_busy = 1'b0;
    logic tie_low   = 1'b0;

    // Transmitter model: busy starts the edge after a sampled tx_start; unaffected by rst.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.tx_start && !tie_low) begin
            model_cnt <= busy_len;
        end else if (model_cnt != 0) begin
            model_cnt <= model_cnt - 1;
        end
    end

    assign bus.tx_busy = hold_busy | (model_cnt != 0);

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.tx_start) begin
                launches++;
                prev_start = last_start;
                last_start = cyc;
                $display("launch data=0x%02h cyc=%0d", bus.tx_data, cyc);
                check_val("start_while_busy", 32'(bus.tx_busy), 32'd0);
                check_val("launch_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check_val("tx_data_order", 32'(bus.tx_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic push_byte(input logic [7:0] b, input bit will_launch);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        if (will_launch) begin
            exp_q.push_back(b);
        end
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_idle();
        int quiet;
        quiet = 0;
        for (int i = 0; i < 1000 && quiet < 8; i++) begin
            @(negedge clk);
            if (bus.empty && !bus.tx_busy) quiet++;
            else quiet = 0;
        end
        check_val("idle_reached", 32'(quiet >= 8), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        int n1;
        int w;

        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        check_val("rst_count",    32'(bus.count),    32'd0);
        check_val("rst_empty",    32'(bus.empty),    32'd1);
        check_val("rst_full",     32'(bus.full),     32'd0);
        check_val("rst_tx_start", 32'(bus.tx_start), 32'd0);
        check_val("rst_tx_data",  32'(bus.tx_data),  32'd0);
`ifdef TX_BYTE_QUEUE_OVERFLOW_EN
        check_val("rst_overflow", 32'(bus.overflow), 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Single byte: launch two edges after the push, one-cycle strobe
        busy_len = 10;
        n0 = launches;
        push_byte(8'h41, 1'b1);
        check_val("lat_edge_n_start", 32'(bus.tx_start), 32'd0);
        check_val("lat_edge_n_count", 32'(bus.count),    32'd1);
        @(negedge clk);
        check_val("lat_edge_n1_start", 32'(bus.tx_start), 32'd1);
        check_val("lat_edge_n1_data",  32'(bus.tx_data),  32'h41);
        check_val("lat_edge_n1_empty", 32'(bus.empty),    32'd1);
        @(negedge clk);
        check_val("pulse_width", 32'(bus.tx_start), 32'd0);
        wait_idle();
        check_val("single_launch", 32'(launches - n0), 32'd1);

        // Fill while transmitter held busy
        hold_busy = 1'b1;
        n0 = launches;
        for (int i = 1; i <= 8; i++) begin
            push_byte(8'(i), 1'b1);
        end
        check_val("fill_full",  32'(bus.full),  32'd1);
        check_val("fill_count", 32'(bus.count), 32'd8);
        repeat (5) @(negedge clk);
        check_val("held_no_launch", 32'(launches - n0), 32'd0);
        check_val("held_count",     32'(bus.count),     32'd8);

        // Write while full coincides with the first pop: must be dropped
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'hEE;
        hold_busy   = 1'b0;
        @(negedge clk);
        bus.wr_en = 1'b0;
        check_val("drop_count", 32'(bus.count), 32'd7);
        check_val("drop_full",  32'(bus.full),  32'd0);
`ifdef TX_BYTE_QUEUE_OVERFLOW_EN
        check_val("overflow_set", 32'(bus.overflow), 32'd1);
`endif
        busy_len = 3;
        wait_idle();
        check_val("fill_launches", 32'(launches - n0), 32'd8);
        check_val("fill_drained",  32'(bus.count),     32'd0);
`ifdef TX_BYTE_QUEUE_OVERFLOW_EN
        check_val("overflow_held", 32'(bus.overflow), 32'd1);
`endif

        // Slow transmitter, 20 bytes at one per 3 cycles, pointer wrap
        busy_len = 12;
        n0 = launches;
        for (int i = 0; i < 20; i++) begin
            w = 0;
            while (bus.full && w < 200) begin
                @(negedge clk);
                w++;
            end
            push_byte(8'h10 + 8'(i), 1'b1);
            repeat (2) @(negedge clk);
        end
        wait_idle();
        check_val("stream_launches", 32'(launches - n0), 32'd20);

        // Lost handshake: busy never rises, recovery after four WAIT_BUSY cycles
        tie_low = 1'b1;
        n0 = launches;
        push_byte(8'h55, 1'b1);
        push_byte(8'h66, 1'b1);
        wait_idle();
        check_val("lost_launches", 32'(launches - n0),          32'd2);
        check_val("lost_gap",      32'(last_start - prev_start), 32'd6);
        tie_low = 1'b0;

        // Asynchronous reset during WAIT_DONE with three bytes queued
        busy_len = 30;
        n0 = launches;
        push_byte(8'hA0, 1'b1);
        w = 0;
        while (launches == n0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check_val("rst_test_launched", 32'(launches - n0), 32'd1);
        repeat (3) @(negedge clk);
        push_byte(8'hA1, 1'b0);
        push_byte(8'hA2, 1'b0);
        push_byte(8'hA3, 1'b0);
        check_val("pre_rst_count", 32'(bus.count), 32'd3);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_val("async_rst_count", 32'(bus.count),    32'd0);
        check_val("async_rst_empty", 32'(bus.empty),    32'd1);
        check_val("async_rst_start", 32'(bus.tx_start), 32'd0);
`ifdef TX_BYTE_QUEUE_OVERFLOW_EN
        check_val("async_rst_overflow", 32'(bus.overflow), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        n1 = launches;
        repeat (40) @(negedge clk);
        check_val("no_launch_after_rst", 32'(launches - n1), 32'd0);
        push_byte(8'hB0, 1'b1);
        wait_idle();
        check_val("post_rst_launch", 32'(launches - n1), 32'd1);

        check_val("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
